// File: rtl/led_seq_pkg.sv
// Shared definitions for the LED pattern sequencer: mode encodings,
// FSM state encodings and the prescaler divide helper.
package led_seq_pkg;

    localparam logic [1:0] MODE_OFF    = 2'd0;
    localparam logic [1:0] MODE_BLINK  = 2'd1;
    localparam logic [1:0] MODE_CHASE  = 2'd2;
    localparam logic [1:0] MODE_BOUNCE = 2'd3;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_LOAD = 2'd1;
    localparam state_t ST_RUN  = 2'd2;

    // Number of clk cycles per dwell tick.
    function automatic int calc_div(input int clk_hz, input int tick_hz);
        return clk_hz / tick_hz;
    endfunction

endpackage

// File: rtl/led_seq_tick.sv
// Dwell-tick prescaler: counts 0..DIV-1 while enabled and pulses o_tick
// for one cycle in the cycle where the count wraps. i_clr has priority.
module led_seq_tick #(
    parameter int DIV = 10
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] r_cnt;

    assign o_tick = i_en && (r_cnt == CW'(DIV - 1));

    // Prescaler count with synchronous clear and wrap at DIV-1.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= o_tick ? '0 : r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/led_seq_ctrl.sv
// LED pattern sequencer (off / blink / chase / bounce) with a programmable
// dwell of ticks per step. Optional brightness PWM is enabled with the
// LED_SEQ_PWM_EN macro; without it cmd_duty is ignored.
//
// state | meaning
// IDLE  | LEDs dark, waiting for a command
// LOAD  | one cycle: counters cleared, initial pattern loaded at exit
// RUN   | pattern steps every dwell ticks
module led_seq_ctrl
    import led_seq_pkg::*;
#(
    parameter int CLK_HZ   = 50_000_000,
    parameter int TICK_HZ  = 1000,
    parameter int DWELL_W  = 16,
    parameter int NUM_LEDS = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_mode,
    input  logic [DWELL_W-1:0]  cmd_dwell,
    input  logic [7:0]          cmd_duty,
    input  logic                stop,
    output logic [NUM_LEDS-1:0] led,
    output logic                busy,
    output logic                step_strobe
);

    localparam int DIV = calc_div(CLK_HZ, TICK_HZ);

    state_t              r_state;
    logic [1:0]          r_mode;
    logic [DWELL_W-1:0]  r_dwell;
    logic [DWELL_W-1:0]  r_dwell_cnt;
    logic [NUM_LEDS-1:0] r_pattern;
    logic                r_dir;
    logic                r_step_strobe;

    logic                w_accept;
    logic                w_tick;
    logic                w_run;
    logic [DWELL_W-1:0]  w_dwell_last;
    logic [NUM_LEDS-1:0] w_next_pattern;
    logic                w_next_dir;

    assign cmd_ready    = (r_state != ST_LOAD) && !stop;
    assign w_accept     = cmd_valid && cmd_ready;
    assign busy         = (r_state == ST_LOAD) || (r_state == ST_RUN);
    assign step_strobe  = r_step_strobe;
    assign w_run        = (r_state == ST_RUN);
    assign w_dwell_last = r_dwell - DWELL_W'(1);

    led_seq_tick #(.DIV(DIV)) u_tick (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_clr   (!w_run),
        .i_en    (w_run),
        .o_tick  (w_tick)
    );

    // Next pattern and bounce direction for one step of the current mode.
    always_comb begin
        w_next_pattern = r_pattern;
        w_next_dir     = r_dir;
        case (r_mode)
            MODE_BLINK: w_next_pattern = ~r_pattern;
            MODE_CHASE: w_next_pattern = {r_pattern[NUM_LEDS-2:0], r_pattern[NUM_LEDS-1]};
            MODE_BOUNCE: begin
                if (r_dir) begin
                    w_next_pattern = r_pattern << 1;
                    if (r_pattern[NUM_LEDS-2]) w_next_dir = 1'b0;
                end else begin
                    w_next_pattern = r_pattern >> 1;
                    if (r_pattern[1]) w_next_dir = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // FSM, command latch, dwell counter and pattern register.
    // Stop beats a new command; a new command beats a pending step.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_mode        <= MODE_OFF;
            r_dwell       <= DWELL_W'(1);
            r_dwell_cnt   <= '0;
            r_pattern     <= '0;
            r_dir         <= 1'b1;
            r_step_strobe <= 1'b0;
        end else begin
            r_step_strobe <= 1'b0;
            if (stop && (r_state != ST_IDLE)) begin
                r_state   <= ST_IDLE;
                r_pattern <= '0;
            end else if (w_accept) begin
                r_mode      <= cmd_mode;
                r_dwell     <= (cmd_dwell == '0) ? DWELL_W'(1) : cmd_dwell;
                r_dwell_cnt <= '0;
                if (cmd_mode == MODE_OFF) begin
                    r_state   <= ST_IDLE;
                    r_pattern <= '0;
                end else begin
                    r_state <= ST_LOAD;
                end
            end else begin
                case (r_state)
                    ST_LOAD: begin
                        r_state     <= ST_RUN;
                        r_dwell_cnt <= '0;
                        r_dir       <= 1'b1;
                        r_pattern   <= (r_mode == MODE_BLINK) ? '1 : NUM_LEDS'(1);
                    end
                    ST_RUN: begin
                        if (w_tick) begin
                            if (r_dwell_cnt == w_dwell_last) begin
                                r_dwell_cnt   <= '0;
                                r_pattern     <= w_next_pattern;
                                r_dir         <= w_next_dir;
                                r_step_strobe <= 1'b1;
                            end else begin
                                r_dwell_cnt <= r_dwell_cnt + DWELL_W'(1);
                            end
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

`ifdef LED_SEQ_PWM_EN
    logic [7:0] r_pwm_cnt;
    logic [7:0] r_duty;

    // Free-running PWM counter and duty latched with each accepted command.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pwm_cnt <= '0;
            r_duty    <= '0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + 8'd1;
            if (w_accept) r_duty <= cmd_duty;
        end
    end

    assign led = r_pattern & {NUM_LEDS{r_pwm_cnt < r_duty}};
`else
    logic w_unused_duty;

    assign w_unused_duty = ^cmd_duty;
    assign led           = r_pattern;
`endif

endmodule

// File: tb/tb_led_seq_ctrl.sv
module tb_led_seq_ctrl;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_mode;
    logic [15:0] cmd_dwell;
    logic [7:0]  cmd_duty;
    logic        stop;
    logic [7:0]  led;
    logic        busy;
    logic        step_strobe;

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_q[$];

    led_seq_ctrl #(
        .CLK_HZ(1000), .TICK_HZ(100), .DWELL_W(16), .NUM_LEDS(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_mode(cmd_mode), .cmd_dwell(cmd_dwell), .cmd_duty(cmd_duty),
        .stop(stop), .led(led), .busy(busy), .step_strobe(step_strobe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called at a negedge; the following posedge is the accept edge.
    task automatic send(input logic [1:0] m, input logic [15:0] d, input logic [7:0] du);
        cmd_mode  = m;
        cmd_dwell = d;
        cmd_duty  = du;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (led !== 8'h00) begin errors++; $display("FAIL reset_led got=%h exp=00", led); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        rst_n = 1'b1;
        #1;
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", cmd_ready); end
        @(negedge clk);
    endtask

    task automatic test_chase;
        int n;
        logic [7:0] e;
        send(2'd2, 16'd2, 8'd255);
        for (int i = 1; i < 8; i++) exp_q.push_back(8'h01 << i);
        exp_q.push_back(8'h01);
        @(negedge clk);
        checks++; if (busy !== 1'b1 || cmd_ready !== 1'b0) begin errors++; $display("FAIL chase_load busy=%b ready=%b exp 1/0", busy, cmd_ready); end
        @(negedge clk);
        checks++; if (led !== 8'h01) begin errors++; $display("FAIL chase_init got=%h exp=01", led); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n = 0;
            do begin @(negedge clk); n++; end while (step_strobe !== 1'b1 && n < 100);
            checks++; if (step_strobe !== 1'b1 || n != 20) begin errors++; $display("FAIL chase_interval got=%0d exp=20", n); end
            checks++; if (led !== e) begin errors++; $display("FAIL chase_led got=%h exp=%h", led, e); end
        end
    endtask

    task automatic test_bounce;
        int n;
        logic [7:0] e;
        send(2'd3, 16'd1, 8'd255);
        for (int i = 1; i < 8; i++) exp_q.push_back(8'h01 << i);
        for (int i = 6; i >= 0; i--) exp_q.push_back(8'h01 << i);
        exp_q.push_back(8'h02);
        repeat (2) @(negedge clk);
        checks++; if (led !== 8'h01) begin errors++; $display("FAIL bounce_init got=%h exp=01", led); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n = 0;
            do begin @(negedge clk); n++; end while (step_strobe !== 1'b1 && n < 100);
            checks++; if (step_strobe !== 1'b1 || n != 10) begin errors++; $display("FAIL bounce_interval got=%0d exp=10", n); end
            checks++; if (led !== e) begin errors++; $display("FAIL bounce_led got=%h exp=%h", led, e); end
        end
    endtask

    task automatic test_blink;
        int n;
        logic [7:0] e;
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL blink_ready_pre got=%b exp=1", cmd_ready); end
        send(2'd1, 16'd0, 8'd255);
        exp_q.push_back(8'h00); exp_q.push_back(8'hFF);
        exp_q.push_back(8'h00); exp_q.push_back(8'hFF);
        @(negedge clk);
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL blink_ready_load got=%b exp=0", cmd_ready); end
        @(negedge clk);
        checks++; if (cmd_ready !== 1'b1 || led !== 8'hFF) begin errors++; $display("FAIL blink_run ready=%b led=%h exp 1/ff", cmd_ready, led); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n = 0;
            do begin @(negedge clk); n++; end while (step_strobe !== 1'b1 && n < 100);
            checks++; if (step_strobe !== 1'b1 || n != 10) begin errors++; $display("FAIL blink_interval got=%0d exp=10", n); end
            checks++; if (led !== e) begin errors++; $display("FAIL blink_led got=%h exp=%h", led, e); end
        end
    endtask

    task automatic test_stop;
        int strobes;
        stop      = 1'b1;
        cmd_mode  = 2'd2;
        cmd_dwell = 16'd1;
        cmd_valid = 1'b1;
        #1;
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL stop_ready got=%b exp=0", cmd_ready); end
        @(posedge clk);
        #1 stop = 1'b0; cmd_valid = 1'b0;
        @(negedge clk);
        checks++; if (led !== 8'h00 || busy !== 1'b0) begin errors++; $display("FAIL stop_idle led=%h busy=%b exp 00/0", led, busy); end
        strobes = 0;
        repeat (30) begin
            @(negedge clk);
            if (step_strobe === 1'b1 || led !== 8'h00 || busy !== 1'b0) strobes++;
        end
        checks++; if (strobes != 0) begin errors++; $display("FAIL stop_quiet activity=%0d exp=0", strobes); end
    endtask

    task automatic test_rechase;
        int n;
        send(2'd1, 16'd1, 8'd255);
        repeat (2) @(negedge clk);
        n = 0;
        do begin @(negedge clk); n++; end while (step_strobe !== 1'b1 && n < 100);
        checks++; if (led !== 8'h00 || n != 10) begin errors++; $display("FAIL rechase_blink led=%h n=%0d exp 00/10", led, n); end
        repeat (9) @(negedge clk);
        send(2'd2, 16'd2, 8'd255);
        exp_q.push_back(8'h02);
        repeat (2) @(negedge clk);
        checks++; if (led !== 8'h01 || step_strobe !== 1'b0) begin errors++; $display("FAIL rechase_init led=%h strobe=%b exp 01/0", led, step_strobe); end
        n = 0;
        do begin @(negedge clk); n++; end while (step_strobe !== 1'b1 && n < 100);
        checks++; if (step_strobe !== 1'b1 || n != 20) begin errors++; $display("FAIL rechase_interval got=%0d exp=20", n); end
        checks++; if (led !== exp_q[0]) begin errors++; $display("FAIL rechase_led got=%h exp=%h", led, exp_q[0]); end
        void'(exp_q.pop_front());
    endtask

    task automatic test_mode_off;
        send(2'd0, 16'd1, 8'd255);
        @(negedge clk);
        checks++; if (led !== 8'h00 || busy !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL off led=%h busy=%b ready=%b exp 00/0/1", led, busy, cmd_ready); end
    endtask

    task automatic test_reset_mid_run;
        int act;
        send(2'd2, 16'd1, 8'd255);
        repeat (15) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (led !== 8'h00 || busy !== 1'b0 || step_strobe !== 1'b0) begin errors++; $display("FAIL rst_run led=%h busy=%b strobe=%b exp 00/0/0", led, busy, step_strobe); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_run_ready got=%b exp=1", cmd_ready); end
        act = 0;
        repeat (25) begin
            @(negedge clk);
            if (step_strobe === 1'b1 || led !== 8'h00) act++;
        end
        checks++; if (act != 0) begin errors++; $display("FAIL rst_run_quiet activity=%0d exp=0", act); end
    endtask

`ifdef LED_SEQ_PWM_EN
    task automatic test_pwm;
        int on_cnt;
        int strobes;
        send(2'd2, 16'd100, 8'd64);
        repeat (2) @(negedge clk);
        on_cnt = 0;
        repeat (256) begin
            @(negedge clk);
            if (led[0] === 1'b1) on_cnt++;
        end
        checks++; if (on_cnt != 64) begin errors++; $display("FAIL pwm_duty64 on=%0d exp=64", on_cnt); end
        send(2'd2, 16'd1, 8'd0);
        on_cnt = 0;
        strobes = 0;
        repeat (50) begin
            @(negedge clk);
            if (led !== 8'h00) on_cnt++;
            if (step_strobe === 1'b1) strobes++;
        end
        checks++; if (on_cnt != 0) begin errors++; $display("FAIL pwm_duty0 lit=%0d exp=0", on_cnt); end
        checks++; if (strobes != 4) begin errors++; $display("FAIL pwm_strobe got=%0d exp=4", strobes); end
    endtask
`endif

    initial begin
        cmd_valid = 1'b0;
        cmd_mode  = 2'd0;
        cmd_dwell = 16'd0;
        cmd_duty  = 8'd0;
        stop      = 1'b0;
        rst_n     = 1'b0;
        @(negedge clk);
        test_reset();
`ifdef LED_SEQ_PWM_EN
        test_pwm();
`else
        test_chase();
        test_bounce();
        test_blink();
        test_stop();
        test_rechase();
        test_mode_off();
        test_reset_mid_run();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
